// File: rtl/ps2_hex_entry.sv
// PS/2 set-2 scan-code to hex-digit entry register with break/extended prefix
// handling, backspace, escape and enter (commit).
module ps2_hex_entry #(
  parameter int NUM_DIGITS = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [7:0]              scan_code,
  input  logic                    scan_valid,
  output logic [4*NUM_DIGITS-1:0] entry,
  output logic [3:0]              digit_count,
  output logic [4*NUM_DIGITS-1:0] value,
  output logic                    value_valid,
  output logic                    reject
);

  localparam int         W     = 4 * NUM_DIGITS;
  localparam logic [3:0] MAX_D = 4'(NUM_DIGITS);

  typedef enum logic [1:0] {IDLE, BREAK, EXT, EXT_BREAK} state_t;

  state_t         r_state, w_state_next;
  logic [W-1:0]   r_entry, w_entry_next;
  logic [3:0]     r_count, w_count_next;
  logic [W-1:0]   r_value, w_value_next;
  logic           r_value_valid, w_value_valid_next;
  logic           r_reject, w_reject_next;
  logic           w_is_hex;
  logic [3:0]     w_nibble;

  always_comb begin
    w_is_hex = 1'b1;
    w_nibble = 4'h0;
    case (scan_code)
      8'h45: w_nibble = 4'h0;
      8'h16: w_nibble = 4'h1;
      8'h1E: w_nibble = 4'h2;
      8'h26: w_nibble = 4'h3;
      8'h25: w_nibble = 4'h4;
      8'h2E: w_nibble = 4'h5;
      8'h36: w_nibble = 4'h6;
      8'h3D: w_nibble = 4'h7;
      8'h3E: w_nibble = 4'h8;
      8'h46: w_nibble = 4'h9;
      8'h1C: w_nibble = 4'hA;
      8'h32: w_nibble = 4'hB;
      8'h21: w_nibble = 4'hC;
      8'h23: w_nibble = 4'hD;
      8'h24: w_nibble = 4'hE;
      8'h2B: w_nibble = 4'hF;
      default: w_is_hex = 1'b0;
    endcase
  end

  always_comb begin
    w_state_next       = r_state;
    w_entry_next       = r_entry;
    w_count_next       = r_count;
    w_value_next       = r_value;
    w_value_valid_next = 1'b0;
    w_reject_next      = 1'b0;
    if (scan_valid) begin
      case (r_state)
        IDLE: begin
          if (scan_code == 8'hF0) begin
            w_state_next = BREAK;
          end else if (scan_code == 8'hE0) begin
            w_state_next = EXT;
          end else if (w_is_hex) begin
            if (r_count < MAX_D) begin
              w_entry_next = (r_entry << 4) | W'(w_nibble);
              w_count_next = r_count + 4'd1;
            end else begin
              w_reject_next = 1'b1;
            end
          end else if (scan_code == 8'h66) begin
            if (r_count != 4'd0) begin
              w_entry_next = r_entry >> 4;
              w_count_next = r_count - 4'd1;
            end else begin
              w_reject_next = 1'b1;
            end
          end else if (scan_code == 8'h5A) begin
            w_value_next       = r_entry;
            w_value_valid_next = 1'b1;
            w_entry_next       = '0;
            w_count_next       = 4'd0;
          end else if (scan_code == 8'h76) begin
            w_entry_next = '0;
            w_count_next = 4'd0;
          end
        end
        EXT: begin
          w_state_next = IDLE;
          if (scan_code == 8'hF0) begin
            w_state_next = EXT_BREAK;
          end else if (scan_code == 8'h5A) begin
            // Keypad enter commits exactly like the main enter key
            w_value_next       = r_entry;
            w_value_valid_next = 1'b1;
            w_entry_next       = '0;
            w_count_next       = 4'd0;
          end
        end
        default: w_state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= IDLE;
      r_entry       <= '0;
      r_count       <= 4'd0;
      r_value       <= '0;
      r_value_valid <= 1'b0;
      r_reject      <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_entry       <= w_entry_next;
      r_count       <= w_count_next;
      r_value       <= w_value_next;
      r_value_valid <= w_value_valid_next;
      r_reject      <= w_reject_next;
    end
  end

  assign entry       = r_entry;
  assign digit_count = r_count;
  assign value       = r_value;
  assign value_valid = r_value_valid;
  assign reject      = r_reject;

endmodule

// File: tb/tb_ps2_hex_entry.sv
// Directed scoreboard bench for ps2_hex_entry (NUM_DIGITS=4): a reference model
// pushes the expected post-byte state, which is popped and compared a cycle later.
module tb_ps2_hex_entry;

  localparam int N = 4;

  logic            clock = 1'b0;
  logic            reset = 1'b0;
  logic [7:0]      scan_code = 8'h00;
  logic            scan_valid = 1'b0;
  logic [4*N-1:0]  entry;
  logic [3:0]      digit_count;
  logic [4*N-1:0]  value;
  logic            value_valid;
  logic            reject;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [15:0] entry;
    logic [3:0]  cnt;
    logic [15:0] value;
    logic        vv;
    logic        rej;
  } exp_t;

  exp_t sb_q[$];

  // reference model state: 0 idle, 1 break, 2 ext, 3 ext-break
  int          m_st;
  logic [15:0] m_entry;
  int          m_cnt;
  logic [15:0] m_value;

  ps2_hex_entry #(.NUM_DIGITS(N)) dut (
    .clock       (clock),
    .reset       (reset),
    .scan_code   (scan_code),
    .scan_valid  (scan_valid),
    .entry       (entry),
    .digit_count (digit_count),
    .value       (value),
    .value_valid (value_valid),
    .reject      (reject)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int hexval(input logic [7:0] b);
    logic [7:0] tbl [16];
    tbl = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
            8'h3E, 8'h46, 8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B};
    for (int k = 0; k < 16; k++) if (tbl[k] == b) return k;
    return -1;
  endfunction

  task automatic model_byte(input logic [7:0] b, output exp_t e);
    int h;
    e.vv  = 1'b0;
    e.rej = 1'b0;
    h = hexval(b);
    case (m_st)
      0: begin
        if (b == 8'hF0) m_st = 1;
        else if (b == 8'hE0) m_st = 2;
        else if (h >= 0) begin
          if (m_cnt < N) begin
            m_entry = m_entry * 16 + 16'(h);
            m_cnt++;
          end else e.rej = 1'b1;
        end else if (b == 8'h66) begin
          if (m_cnt > 0) begin
            m_entry = m_entry / 16;
            m_cnt--;
          end else e.rej = 1'b1;
        end else if (b == 8'h5A) begin
          m_value = m_entry; e.vv = 1'b1; m_entry = 0; m_cnt = 0;
        end else if (b == 8'h76) begin
          m_entry = 0; m_cnt = 0;
        end
      end
      2: begin
        if (b == 8'hF0) m_st = 3;
        else begin
          m_st = 0;
          if (b == 8'h5A) begin
            m_value = m_entry; e.vv = 1'b1; m_entry = 0; m_cnt = 0;
          end
        end
      end
      default: m_st = 0;
    endcase
    e.entry = m_entry;
    e.cnt   = 4'(m_cnt);
    e.value = m_value;
  endtask

  task automatic model_reset();
    m_st = 0; m_entry = 0; m_cnt = 0; m_value = 0;
  endtask

  task automatic send(input logic [7:0] b);
    exp_t e;
    @(negedge clock);
    scan_code  = b;
    scan_valid = 1'b1;
    model_byte(b, e);
    sb_q.push_back(e);
    @(posedge clock);
    #1;
    scan_valid = 1'b0;
    e = sb_q.pop_front();
    $display("byte %02h -> entry=%04h cnt=%0d value=%04h vv=%0b rej=%0b",
             b, entry, digit_count, value, value_valid, reject);
    chk($sformatf("entry[%02h]", b), 32'(entry), 32'(e.entry));
    chk($sformatf("count[%02h]", b), 32'(digit_count), 32'(e.cnt));
    chk($sformatf("value[%02h]", b), 32'(value), 32'(e.value));
    chk($sformatf("vv[%02h]", b), 32'(value_valid), 32'(e.vv));
    chk($sformatf("rej[%02h]", b), 32'(reject), 32'(e.rej));
    @(posedge clock);
    #1;
    chk("vv_idle", 32'(value_valid), 32'd0);
    chk("rej_idle", 32'(reject), 32'd0);
  endtask

  task automatic send_seq(input logic [7:0] bytes[$]);
    foreach (bytes[k]) send(bytes[k]);
  endtask

  task automatic do_reset(input logic with_strobe);
    @(negedge clock);
    reset      = 1'b1;
    scan_valid = with_strobe;
    scan_code  = 8'h16;
    @(posedge clock);
    #1;
    reset      = 1'b0;
    scan_valid = 1'b0;
    model_reset();
    $display("reset -> entry=%04h cnt=%0d value=%04h vv=%0b rej=%0b",
             entry, digit_count, value, value_valid, reject);
    chk("rst_entry", 32'(entry), 32'd0);
    chk("rst_count", 32'(digit_count), 32'd0);
    chk("rst_value", 32'(value), 32'd0);
    chk("rst_vv", 32'(value_valid), 32'd0);
    chk("rst_rej", 32'(reject), 32'd0);
  endtask

  initial begin
    model_reset();
    do_reset(1'b0);

    // make/break pairs build 0x0123
    send_seq('{8'h16, 8'hF0, 8'h16, 8'h1E, 8'hF0, 8'h1E, 8'h26, 8'hF0, 8'h26});
    chk("t1_entry", 32'(entry), 32'h0123);
    chk("t1_count", 32'(digit_count), 32'd3);

    send(8'h5A);
    chk("t2_value", 32'(value), 32'h0123);
    chk("t2_entry", 32'(entry), 32'd0);

    send_seq('{8'h16, 8'h1E, 8'h66});
    chk("t3_entry", 32'(entry), 32'h0001);
    send_seq('{8'h66, 8'h66});

    // fill to capacity, fifth digit rejected
    send_seq('{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E});
    chk("t4_entry", 32'(entry), 32'h1234);
    chk("t4_count", 32'(digit_count), 32'd4);

    send(8'h76);
    chk("esc_entry", 32'(entry), 32'd0);

    send_seq('{8'h16, 8'hE0, 8'hF0, 8'h5A, 8'hE0, 8'h5A});
    chk("t5_value", 32'(value), 32'h0001);

    // empty commit, ignored codes, extended non-enter, typematic repeats, A-F
    send(8'h5A);
    chk("empty_commit", 32'(value), 32'd0);
    send_seq('{8'h00, 8'hE0, 8'h16, 8'h1C, 8'h1C, 8'h1C, 8'h32, 8'h2B, 8'h45});
    send_seq('{8'h21, 8'h23, 8'h24, 8'h36, 8'h3D, 8'h3E, 8'h46, 8'h5A});

    // reset mid-prefix discards the F0
    send(8'hF0);
    do_reset(1'b0);
    send(8'h16);
    chk("t6_entry", 32'(entry), 32'h0001);
    chk("t6_value", 32'(value), 32'd0);

    // reset wins over a simultaneous strobe
    do_reset(1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
